data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 15 +
 rtl/arb_id_fifo.sv | 58 +++++
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester IDs.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND_CORE = 2'd1,
        PEND_SEC  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_SEC  = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
module arb_id_fifo
    import data_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_e push_id,
    input  logic    pop,
    output req_id_e head_id,
    output logic    empty,
    output logic    full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    req_id_e          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head_id = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (core, secondary) onto one data-memory port with
// bounded outstanding transactions and starvation protection for the secondary.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_data_req,
    input  logic             core_data_we,
    input  logic [WIDTH-1:0] core_data_addr,
    input  logic [WIDTH-1:0] core_data_wdata,
    output logic             core_data_gnt,
    output logic             core_data_rvalid,
    output logic [WIDTH-1:0] core_data_rdata,
    input  logic             sec_data_req,
    input  logic             sec_data_we,
    input  logic [WIDTH-1:0] sec_data_addr,
    input  logic [WIDTH-1:0] sec_data_wdata,
    output logic             sec_data_gnt,
    output logic             sec_data_rvalid,
    output logic [WIDTH-1:0] sec_data_rdata,
    output logic             data_mem_req,
    output logic             data_mem_we,
    output logic [WIDTH-1:0] data_mem_addr,
    output logic [WIDTH-1:0] data_mem_wdata,
    input  logic             data_mem_gnt,
    input  logic             data_mem_rvalid,
    input  logic [WIDTH-1:0] data_mem_rdata
);

    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    logic [SCNT_W-1:0] starve_q;
    logic [SCNT_W-1:0] starve_d;
    req_id_e           owner;
    req_id_e           head_id;
    logic              owner_vld;
    logic              owner_req;
    logic              issue;
    logic              accept;
    logic              rsp;
    logic              fifo_empty;
    logic              fifo_full;

    always_comb begin
        owner_vld = 1'b1;
        owner     = REQ_CORE;
        case (state_q)
            PEND_CORE: owner = REQ_CORE;
            PEND_SEC:  owner = REQ_SEC;
            default: begin
                if (sec_data_req && starve_q == SCNT_W'(STARVE_LIMIT)) owner = REQ_SEC;
                else if (core_data_req)                                 owner = REQ_CORE;
                else if (sec_data_req)                                  owner = REQ_SEC;
                else                                                    owner_vld = 1'b0;
            end
        endcase
    end

    // All outputs are forced low while rst is high, not just after the edge.
    assign owner_req = owner_vld && ((owner == REQ_SEC) ? sec_data_req : core_data_req);
    assign issue     = !rst && owner_req && !fifo_full;
    assign accept    = issue && data_mem_gnt;
    assign rsp       = !rst && data_mem_rvalid && !fifo_empty;

    assign data_mem_req = issue;

    always_comb begin
        data_mem_we    = 1'b0;
        data_mem_addr  = '0;
        data_mem_wdata = '0;
        if (issue) begin
            if (owner == REQ_SEC) begin
                data_mem_we    = sec_data_we;
                data_mem_addr  = sec_data_addr;
                data_mem_wdata = sec_data_wdata;
            end else begin
                data_mem_we    = core_data_we;
                data_mem_addr  = core_data_addr;
                data_mem_wdata = core_data_wdata;
            end
        end
    end

    assign core_data_gnt    = accept && (owner == REQ_CORE);
    assign sec_data_gnt     = accept && (owner == REQ_SEC);
    assign core_data_rvalid = rsp && (head_id == REQ_CORE);
    assign sec_data_rvalid  = rsp && (head_id == REQ_SEC);
    assign core_data_rdata  = core_data_rvalid ? data_mem_rdata : '0;
    assign sec_data_rdata   = sec_data_rvalid  ? data_mem_rdata : '0;

    always_comb begin
        if (!sec_data_req || sec_data_gnt)              starve_d = '0;
        else if (starve_q != SCNT_W'(STARVE_LIMIT))     starve_d = starve_q + 1'b1;
        else                                            starve_d = starve_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    // Lock the owner only once its request is actually on the bus.
                    if (issue && !data_mem_gnt)
                        state_q <= (owner == REQ_SEC) ? PEND_SEC : PEND_CORE;
                end
                default: begin
                    if (accept) state_q <= IDLE;
                end
            endcase
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (owner),
        .pop     (rsp),
        .head_id (head_id),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule
